// File: rtl/operand_collector_if.sv
// Put/bundle handshake bundle for the operand collector.
// The producer drives the master modport and the collector uses the slave modport.
interface operand_collector_if #(
  parameter int unsigned W = 8,
  parameter int unsigned N = 3
);
  localparam int unsigned CW = $clog2(N + 1);

  logic              put_valid;
  logic [W-1:0]      put_data;
  logic              put_ready;
  logic [CW-1:0]     need;
  logic              flush;
  logic              bundle_valid;
  logic              bundle_ack;
  logic [N*W-1:0]    operands;
  logic [CW-1:0]     fill_count;
  logic              done_pulse;
  logic              cfg_err;

  modport master (
    output put_valid, put_data, need, flush, bundle_ack,
    input  put_ready, bundle_valid, operands, fill_count, done_pulse, cfg_err
  );

  modport slave (
    input  put_valid, put_data, need, flush, bundle_ack,
    output put_ready, bundle_valid, operands, fill_count, done_pulse, cfg_err
  );
endinterface

// File: rtl/operand_collector.sv
// Collects put words into an N-slot operand bundle.
// The bundle is offered under a valid/ack handshake, and a done pulse follows each consumed bundle.
module operand_collector #(
  parameter int unsigned W = 8,
  parameter int unsigned N = 3
) (
  input  logic               clk,
  input  logic               reset,
  operand_collector_if.slave bus
);
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

  state_t         state;
  logic [N*W-1:0] opsQ;
  logic [CW-1:0]  fillQ;
  logic [CW-1:0]  needQ;
  logic           doneQ;
  logic           errQ;
  logic           needLegal;

  assign needLegal = (bus.need >= CW'(1)) && (bus.need <= CW'(N));

  // The bundle stays in slots that are zeroed on every exit path.
  // As a result, slots at or beyond need_q always read 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      opsQ  <= '0;
      fillQ <= '0;
      needQ <= '0;
      doneQ <= 1'b0;
      errQ  <= 1'b0;
    end else begin
      doneQ <= 1'b0;
      errQ  <= 1'b0;
      if (bus.flush) begin
        state <= IDLE;
        opsQ  <= '0;
        fillQ <= '0;
        needQ <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.put_valid) begin
              opsQ[W-1:0] <= bus.put_data;
              fillQ       <= CW'(1);
              if (needLegal) begin
                needQ <= bus.need;
                state <= (bus.need == CW'(1)) ? HOLD : FILL;
              end else begin
                needQ <= CW'(N);
                errQ  <= 1'b1;
                state <= (N == 1) ? HOLD : FILL;
              end
            end
          end
          FILL: begin
            if (bus.put_valid) begin
              opsQ[int'(fillQ)*W +: W] <= bus.put_data;
              fillQ <= fillQ + CW'(1);
              if (fillQ + CW'(1) == needQ) state <= HOLD;
            end
          end
          HOLD: begin
            if (bus.bundle_ack) begin
              state <= IDLE;
              opsQ  <= '0;
              fillQ <= '0;
              needQ <= '0;
              doneQ <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Ready is gated by reset so the collector refuses words while held in reset.
  assign bus.put_ready    = reset & (state != HOLD) & ~bus.flush;
  assign bus.bundle_valid = (state == HOLD);
  assign bus.operands     = opsQ;
  assign bus.fill_count   = fillQ;
  assign bus.done_pulse   = doneQ;
  assign bus.cfg_err      = errQ;
endmodule
